// File: rtl/pixel_framebuffer.sv
// Banked pixel store between a CPU port (back buffer) and a VGA scan-out port (front buffer),
// with a hardware clear engine and tear-free front/back swaps taken at frame start.
module pixel_framebuffer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int COLOR_BITS = 1,
    parameter int ADDR_WIDTH = 19,
    parameter int DOUBLE_BUF = 1
) (
    input  logic                  clk,
    input  logic                  CPU_RESETN,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [COLOR_BITS-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    output logic [COLOR_BITS-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  cpu_busy,
    input  logic                  clear_req,
    input  logic [COLOR_BITS-1:0] clear_color,
    input  logic                  swap_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    input  logic                  vga_frame_start,
    output logic [COLOR_BITS-1:0] vga_data,
    output logic                  front_sel
);

    localparam int DEPTH     = H_RES * V_RES;
    localparam int NUM_BANKS = DOUBLE_BUF + 1;
    localparam int MEM_WORDS = NUM_BANKS * DEPTH;
    localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CLEAR     = 2'd1,
        S_SWAP_WAIT = 2'd2
    } state_t;

    logic [COLOR_BITS-1:0] mem [MEM_WORDS];

    state_t                state_q, state_d;
    logic                  front_sel_q, front_sel_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [COLOR_BITS-1:0] clr_color_q, clr_color_d;
    logic [COLOR_BITS-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d;
    logic [COLOR_BITS-1:0] vga_data_q, vga_data_d;

    logic                  back_bank, front_bank;
    logic                  cpu_in_range, vga_in_range;
    logic                  wr_en;
    logic [MEM_AW-1:0]     wr_idx;
    logic [COLOR_BITS-1:0] wr_data;

    // Banks are laid out back to back; bank 1 starts at word DEPTH.
    function automatic logic [MEM_AW-1:0] flat_idx(input logic bank,
                                                   input logic [ADDR_WIDTH-1:0] addr);
        flat_idx = (bank ? MEM_AW'(DEPTH) : '0) + MEM_AW'(addr);
    endfunction

    assign back_bank    = (DOUBLE_BUF != 0) ? ~front_sel_q : 1'b0;
    assign front_bank   = (DOUBLE_BUF != 0) ?  front_sel_q : 1'b0;
    assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH_W);
    assign vga_in_range = ({1'b0, vga_addr} < DEPTH_W);

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= S_IDLE;
            front_sel_q  <= 1'b0;
            clr_cnt_q    <= '0;
            clr_color_q  <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            vga_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            front_sel_q  <= front_sel_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_color_q  <= clr_color_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vga_data_q   <= vga_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        case (state_q)
            S_IDLE: begin
                // Clear has priority; a swap raised alongside it is dropped.
                if (clear_req) begin
                    state_d     = S_CLEAR;
                    clr_cnt_d   = '0;
                    clr_color_d = clear_color;
                end else if (swap_req && (DOUBLE_BUF != 0)) begin
                    state_d = S_SWAP_WAIT;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == LAST_IDX) state_d = S_IDLE;
                else                       clr_cnt_d = clr_cnt_q + 1'b1;
            end
            S_SWAP_WAIT: begin
                if (vga_frame_start) begin
                    front_sel_d = ~front_sel_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reads sample the array before this edge's write lands, giving read-before-write on both ports.
    always_comb begin
        cpu_busy     = (state_q != S_IDLE);
        wr_en        = 1'b0;
        wr_idx       = flat_idx(back_bank, cpu_addr);
        wr_data      = cpu_wdata;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        if (state_q == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = flat_idx(back_bank, clr_cnt_q);
            wr_data = clr_color_q;
        end else if (state_q == S_IDLE) begin
            wr_en = cpu_we && cpu_in_range;
            if (cpu_re) begin
                cpu_rvalid_d = 1'b1;
                cpu_rdata_d  = cpu_in_range ? mem[flat_idx(back_bank, cpu_addr)] : '0;
            end
        end
        vga_data_d = vga_in_range ? mem[flat_idx(front_bank, vga_addr)] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign vga_data   = vga_data_q;
    assign front_sel  = front_sel_q;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed bench for pixel_framebuffer on an 8x4, 4-bit, double-buffered configuration.
module tb_pixel_framebuffer;

    localparam int AW = 6;
    localparam int CB = 4;

    logic          clk;
    logic          CPU_RESETN;
    logic [AW-1:0] cpu_addr;
    logic [CB-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_re;
    logic [CB-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          cpu_busy;
    logic          clear_req;
    logic [CB-1:0] clear_color;
    logic          swap_req;
    logic [AW-1:0] vga_addr;
    logic          vga_frame_start;
    logic [CB-1:0] vga_data;
    logic          front_sel;

    int tests_run;
    int tests_failed;
    int n;

    pixel_framebuffer #(
        .H_RES(8), .V_RES(4), .COLOR_BITS(CB), .ADDR_WIDTH(AW), .DOUBLE_BUF(1)
    ) dut (
        .clk(clk), .CPU_RESETN(CPU_RESETN),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_busy(cpu_busy),
        .clear_req(clear_req), .clear_color(clear_color), .swap_req(swap_req),
        .vga_addr(vga_addr), .vga_frame_start(vga_frame_start),
        .vga_data(vga_data), .front_sel(front_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_c(input string tag, input logic [CB-1:0] obs, input logic [CB-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts busy cycles from now until cpu_busy falls, bounded at 100.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (cpu_busy && cycles < 100) begin
            cycles++;
            step();
        end
    endtask

    task automatic do_clear(input logic [CB-1:0] color, input string tag);
        int c;
        clear_req   = 1'b1;
        clear_color = color;
        step();
        clear_req   = 1'b0;
        clear_color = 4'hE;
        wait_idle(c);
        check_n(tag, c, 32);
    endtask

    task automatic do_swap(input logic exp_front, input string tag);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check_b({tag, "_busy"}, cpu_busy, 1'b1);
        check_b({tag, "_hold"}, front_sel, ~exp_front);
        vga_frame_start = 1'b1;
        step();
        vga_frame_start = 1'b0;
        check_b({tag, "_front"}, front_sel, exp_front);
        check_b({tag, "_idle"}, cpu_busy, 1'b0);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        CPU_RESETN = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        clear_req = 1'b0; clear_color = '0; swap_req = 1'b0;
        vga_addr = '0; vga_frame_start = 1'b0;
        step();
        step();
        check_c("rst_rdata", cpu_rdata, 4'h0);
        check_b("rst_rvalid", cpu_rvalid, 1'b0);
        check_b("rst_busy", cpu_busy, 1'b0);
        check_c("rst_vga", vga_data, 4'h0);
        check_b("rst_front", front_sel, 1'b0);
        CPU_RESETN = 1'b1;
        step();

        // Give both banks known contents: zero bank 1, swap, zero bank 0, swap back.
        do_clear(4'h0, "init_clr1");
        do_swap(1'b1, "init_sw1");
        do_clear(4'h0, "init_clr0");
        do_swap(1'b0, "init_sw0");

        // Test 1: write / read-back on the back bank.
        cpu_we = 1'b1; cpu_addr = 6'd5; cpu_wdata = 4'hA;
        step();
        cpu_we = 1'b0; cpu_re = 1'b1;
        step();
        cpu_re = 1'b0;
        check_b("t1_rvalid", cpu_rvalid, 1'b1);
        check_c("t1_rdata", cpu_rdata, 4'hA);
        vga_addr = 6'd5;
        step();
        check_b("t1_rvalid_drop", cpu_rvalid, 1'b0);
        check_c("t1_vga_front", vga_data, 4'h0);

        // Test 2: a frame_start on the accepting cycle does not count.
        swap_req = 1'b1; vga_frame_start = 1'b1;
        step();
        swap_req = 1'b0; vga_frame_start = 1'b0;
        check_b("t2_busy", cpu_busy, 1'b1);
        check_b("t2_front_hold", front_sel, 1'b0);
        step();
        check_b("t2_still_wait", cpu_busy, 1'b1);
        vga_frame_start = 1'b1;
        step();
        vga_frame_start = 1'b0;
        check_b("t2_front", front_sel, 1'b1);
        check_b("t2_idle", cpu_busy, 1'b0);
        check_c("t2_vga_old", vga_data, 4'h0);
        step();
        check_c("t2_vga_new", vga_data, 4'hA);

        // Test 3: clear of bank 0 while bank 1 is displayed.
        do_clear(4'h3, "t3_busy_cycles");
        for (int i = 0; i < 32; i++) begin
            cpu_re = 1'b1; cpu_addr = 6'(i);
            step();
            check_c($sformatf("t3_rd%0d", i), cpu_rdata, 4'h3);
        end
        cpu_re = 1'b0;
        vga_addr = 6'd5;
        step();
        check_c("t3_front5", vga_data, 4'hA);
        vga_addr = 6'd6;
        step();
        check_c("t3_front6", vga_data, 4'h0);

        // Test 4: CPU traffic and requests while busy are dropped.
        clear_req = 1'b1; clear_color = 4'h3;
        step();
        clear_req = 1'b0;
        repeat (20) step();
        cpu_we = 1'b1; cpu_addr = 6'd2; cpu_wdata = 4'hF; cpu_re = 1'b1; swap_req = 1'b1;
        step();
        cpu_we = 1'b0; cpu_re = 1'b0; swap_req = 1'b0;
        check_b("t4_no_rvalid", cpu_rvalid, 1'b0);
        check_b("t4_busy", cpu_busy, 1'b1);
        wait_idle(n);
        check_b("t4_done", cpu_busy, 1'b0);
        step();
        check_b("t4_swap_ignored", cpu_busy, 1'b0);
        cpu_re = 1'b1; cpu_addr = 6'd2;
        step();
        cpu_re = 1'b0;
        check_c("t4_addr2", cpu_rdata, 4'h3);
        clear_req = 1'b1; swap_req = 1'b1; clear_color = 4'h3;
        step();
        clear_req = 1'b0; swap_req = 1'b0;
        wait_idle(n);
        check_n("t4_both_cycles", n, 32);
        vga_frame_start = 1'b1;
        step();
        vga_frame_start = 1'b0;
        check_b("t4_both_front", front_sel, 1'b1);
        check_b("t4_both_idle", cpu_busy, 1'b0);

        // Test 5: out-of-range addresses (40 would alias bank 1 word 8).
        cpu_we = 1'b1; cpu_addr = 6'd40; cpu_wdata = 4'h7;
        step();
        cpu_we = 1'b0; cpu_re = 1'b1;
        step();
        cpu_re = 1'b0;
        check_b("t5_rvalid", cpu_rvalid, 1'b1);
        check_c("t5_rdata", cpu_rdata, 4'h0);
        vga_addr = 6'd40;
        step();
        check_c("t5_vga40", vga_data, 4'h0);
        vga_addr = 6'd8;
        step();
        check_c("t5_vga8", vga_data, 4'h0);
        cpu_re = 1'b1; cpu_addr = 6'd8;
        step();
        cpu_re = 1'b0;
        check_c("t5_back8", cpu_rdata, 4'h3);

        // Test 6: reset after ten clear writes (indices 0..9) into bank 0.
        vga_addr = 6'd5;
        clear_req = 1'b1; clear_color = 4'h9;
        step();
        clear_req = 1'b0;
        repeat (10) step();
        check_b("t6_busy_pre", cpu_busy, 1'b1);
        check_c("t6_vga_pre", vga_data, 4'hA);
        CPU_RESETN = 1'b0;
        #1;
        check_b("t6_busy_rst", cpu_busy, 1'b0);
        check_c("t6_vga_rst", vga_data, 4'h0);
        check_c("t6_rdata_rst", cpu_rdata, 4'h0);
        check_b("t6_front_rst", front_sel, 1'b0);
        step();
        CPU_RESETN = 1'b1;
        step();
        check_b("t6_idle", cpu_busy, 1'b0);
        for (int i = 0; i < 32; i++) begin
            vga_addr = 6'(i);
            step();
            check_c($sformatf("t6_vga%0d", i), vga_data, (i < 10) ? 4'h9 : 4'h3);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
